mesh_port_arbiter: RTL and testbench

- Shares one router output port among N_SRC input FIFOs: the four mesh neighbours plus the local terminal.
- Per-node scheduler inside mesh_gnrtr, placed between the input FIFO heads (pndng/pop/data) and the output FIFO (push/full).
- Round-robin grant with a bounded per-source burst; a registered output stage drives the downstream FIFO.

---
 rtl/mesh_arb_pkg.sv | 19 +
 rtl/mesh_port_arbiter_rr_pick.sv | 35 +++
 rtl/mesh_port_arbiter.sv | 116 +++++++++++
 tb/tb_mesh_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared types and constants for the mesh router output-port arbiter.
package mesh_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int N_SRC_DEF   = 5;
  localparam int PCKG_SZ_DEF = 40;

  // Input FIFO index of each mesh neighbour and of the local terminal
  localparam int N    = 0;
  localparam int S    = 1;
  localparam int E    = 2;
  localparam int W    = 3;
  localparam int TERM = 4;

endpackage

// File: rtl/mesh_port_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_SRC = 5,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] idx,
  output logic             hit
);

  localparam logic [SRC_W:0] N_L = (SRC_W+1)'(N_SRC);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [SRC_W-1:0]   off;
  logic [SRC_W:0]     sum;

  // Rotate so ptr sits at bit 0, priority-encode, then rotate the index back
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_SRC];
    off = '0;
    hit = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SRC_W'(i);
        hit = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= N_L) ? SRC_W'(sum - N_L) : SRC_W'(sum);
  end

endmodule

// File: rtl/mesh_port_arbiter.sv
// Output-port scheduler: round-robin grant, bounded burst, registered push stage.
module mesh_port_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int N_SRC     = N_SRC_DEF,
  parameter int pckg_sz   = PCKG_SZ_DEF,
  parameter int MAX_BURST = 4,
  parameter int SRC_W     = $clog2(N_SRC),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_SRC-1:0]                pndng_i,
  input  logic [N_SRC-1:0][pckg_sz-1:0]   data_i,
  output logic [N_SRC-1:0]                pop_o,
  input  logic                            full_i,
  output logic                            push_o,
  output logic [pckg_sz-1:0]              data_o,
  output logic [N_SRC-1:0]                gnt_o,
  output logic                            busy_o
);

  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state, state_nx;
  logic [SRC_W-1:0] gnt_idx, gnt_nx;
  logic [SRC_W-1:0] ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_hit;
  logic             head_pndng;
  logic             pop_en;
  logic             burst_end;

  rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .req (pndng_i),
    .ptr (ptr),
    .idx (pick_idx),
    .hit (pick_hit)
  );

  // Next-state, burst accounting and pop/grant decode
  always_comb begin
    head_pndng = pndng_i[gnt_idx];
    pop_en     = (state == XFER) && head_pndng && !full_i;
    // A stall with the source still pending keeps the grant; an empty head ends it
    burst_end  = (state == XFER) && (!head_pndng || (pop_en && (cnt == LAST_CNT)));

    state_nx = state;
    gnt_nx   = gnt_idx;
    ptr_nx   = ptr;
    cnt_nx   = cnt;

    case (state)
      IDLE: begin
        if (pick_hit) begin
          gnt_nx   = pick_idx;
          cnt_nx   = '0;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (pop_en) begin
          cnt_nx = cnt + CNT_W'(1);
        end
        if (burst_end) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          ptr_nx   = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + SRC_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    pop_o = '0;
    gnt_o = '0;
    if (state == XFER) begin
      gnt_o[gnt_idx] = 1'b1;
      pop_o[gnt_idx] = pop_en;
    end
    busy_o = (state == XFER);
  end

  // State, grant, round-robin pointer and burst counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      gnt_idx <= gnt_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
    end
  end

  // Registered push stage; a packet popped in the reset cycle is dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      push_o <= 1'b0;
      data_o <= '0;
    end else begin
      push_o <= pop_en;
      if (pop_en) begin
        data_o <= data_i[gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed bench for mesh_port_arbiter with source-FIFO model and push scoreboard.
module tb_mesh_port_arbiter;

  localparam int NS = 5;
  localparam int PW = 40;
  localparam int MB = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NS-1:0]          pndng_i;
  logic [NS-1:0][PW-1:0]  data_i;
  logic [NS-1:0]          pop_o;
  logic                   full_i;
  logic                   push_o;
  logic [PW-1:0]          data_o;
  logic [NS-1:0]          gnt_o;
  logic                   busy_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_push = 0;
  int tag    = 0;
  int rem [NS];
  int nxt [NS];
  logic [PW-1:0] exp_q [$];

  always #5 clk = ~clk;

  mesh_port_arbiter #(
    .N_SRC     (NS),
    .pckg_sz   (PW),
    .MAX_BURST (MB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng_i (pndng_i),
    .data_i  (data_i),
    .pop_o   (pop_o),
    .full_i  (full_i),
    .push_o  (push_o),
    .data_o  (data_o),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input int s, input int n);
    return {8'(tag), 8'(s), 16'h5a5a, 8'(n)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      pndng_i[i] = (rem[i] > 0);
      data_i[i]  = pkt(i, nxt[i]);
    end
    #1;
  endtask

  task automatic load(input int s, input int n);
    rem[s] = n;
    nxt[s] = 0;
  endtask

  task automatic expect_pkts(input int s, input int first, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back(pkt(s, first + k));
  endtask

  // One clock: score pushes at the falling edge, then retire popped heads
  task automatic tick();
    logic [NS-1:0] popped;
    @(negedge clk);
    check("pop_onehot", 64'($onehot0(pop_o)), 64'd1);
    if (push_o === 1'b1) begin
      n_push++;
      if (exp_q.size() == 0) check("push_unexpected", 64'(push_o), 64'd0);
      else                   check("push_data", 64'(data_o), 64'(exp_q.pop_front()));
    end
    popped = pop_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (popped[i] && rem[i] > 0) begin
        rem[i]--;
        nxt[i]++;
      end
    end
    drive();
  endtask

  task automatic drain(input int limit, output int bubbles);
    int k;
    k = 0;
    bubbles = 0;
    if (!busy_o && pndng_i != '0) bubbles++;
    while ((exp_q.size() != 0 || busy_o || pndng_i != '0) && k < limit) begin
      tick();
      k++;
      if (!busy_o && pndng_i != '0) bubbles++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(busy_o), 64'd0);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    full_i = 1'b0;
    for (int i = 0; i < NS; i++) load(i, 0);
    drive();
    tick();
    tick();
    reset = 1'b1;
    tag++;
    drive();
  endtask

  initial begin
    int b;
    int p0;
    reset  = 1'b0;
    full_i = 1'b0;
    for (int i = 0; i < NS; i++) load(i, 0);
    drive();
    tick();
    tick();
    check("rst_gnt",  64'(gnt_o),  64'd0);
    check("rst_pop",  64'(pop_o),  64'd0);
    check("rst_push", 64'(push_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    reset = 1'b1;
    tag   = 1;

    // Single source with three packets
    load(2, 3);
    expect_pkts(2, 0, 3);
    drive();
    check("t1_c0_gnt", 64'(gnt_o), 64'd0);
    tick();
    check("t1_c1_gnt",  64'(gnt_o),  64'(5'b00100));
    check("t1_c1_pop",  64'(pop_o),  64'(5'b00100));
    check("t1_c1_busy", 64'(busy_o), 64'd1);
    tick();
    check("t1_c2_push", 64'(push_o), 64'd1);
    check("t1_c2_data", 64'(data_o), 64'(pkt(2, 0)));
    check("t1_c2_pop",  64'(pop_o),  64'(5'b00100));
    tick();
    check("t1_c3_pop",  64'(pop_o),  64'(5'b00100));
    check("t1_c3_data", 64'(data_o), 64'(pkt(2, 1)));
    tick();
    check("t1_c4_pop",  64'(pop_o),  64'd0);
    check("t1_c4_gnt",  64'(gnt_o),  64'(5'b00100));
    check("t1_c4_push", 64'(push_o), 64'd1);
    check("t1_c4_data", 64'(data_o), 64'(pkt(2, 2)));
    tick();
    check("t1_c5_gnt",  64'(gnt_o),  64'd0);
    check("t1_c5_busy", 64'(busy_o), 64'd0);
    check("t1_c5_push", 64'(push_o), 64'd0);
    // ptr should now be 3: source 3 beats source 0
    load(0, 1);
    load(3, 1);
    expect_pkts(3, 0, 1);
    expect_pkts(0, 0, 1);
    drive();
    tick();
    check("t1_ptr3_gnt", 64'(gnt_o), 64'(5'b01000));
    drain(100, b);

    // All sources with ten packets each
    do_reset();
    for (int s = 0; s < NS; s++) load(s, 10);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NS; s++)
        expect_pkts(s, r * MB, (r == 2) ? 2 : MB);
    drive();
    p0 = n_push;
    drain(400, b);
    check("t2_bubbles", 64'(b), 64'd15);
    check("t2_pushes",  64'(n_push - p0), 64'd50);

    // Back-pressure after two pops
    do_reset();
    load(1, 6);
    load(3, 1);
    expect_pkts(1, 0, 4);
    expect_pkts(3, 0, 1);
    expect_pkts(1, 4, 2);
    drive();
    tick();
    check("t3_c1_gnt", 64'(gnt_o), 64'(5'b00010));
    check("t3_c1_pop", 64'(pop_o), 64'(5'b00010));
    tick();
    tick();
    full_i = 1'b1;
    drive();
    check("t3_c3_pop",  64'(pop_o),  64'd0);
    check("t3_c3_gnt",  64'(gnt_o),  64'(5'b00010));
    check("t3_c3_busy", 64'(busy_o), 64'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t3_stall_push", 64'(push_o), 64'd0);
      check("t3_stall_pop",  64'(pop_o),  64'd0);
      check("t3_stall_gnt",  64'(gnt_o),  64'(5'b00010));
    end
    tick();
    full_i = 1'b0;
    drive();
    check("t3_c6_pop", 64'(pop_o), 64'(5'b00010));
    tick();
    check("t3_c7_pop", 64'(pop_o), 64'(5'b00010));
    tick();
    check("t3_c8_gnt", 64'(gnt_o), 64'd0);
    tick();
    check("t3_c9_gnt", 64'(gnt_o), 64'(5'b01000));
    drain(100, b);

    // Wrap-around from ptr=4
    do_reset();
    load(3, 1);
    expect_pkts(3, 0, 1);
    drive();
    tick();
    tick();
    tick();
    check("t4_idle", 64'(busy_o), 64'd0);
    load(4, 1);
    load(0, 1);
    expect_pkts(4, 0, 1);
    expect_pkts(0, 0, 1);
    drive();
    tick();
    check("t4_gnt4", 64'(gnt_o), 64'(5'b10000));
    drain(100, b);
    load(1, 1);
    load(0, 1);
    expect_pkts(1, 0, 1);
    expect_pkts(0, 0, 1);
    drive();
    tick();
    check("t4_ptr1_gnt", 64'(gnt_o), 64'(5'b00010));
    drain(100, b);

    // Source drains mid-burst
    do_reset();
    load(1, 2);
    expect_pkts(1, 0, 2);
    drive();
    tick();
    check("t5_c1_gnt", 64'(gnt_o), 64'(5'b00010));
    load(0, 1);
    load(3, 1);
    expect_pkts(3, 0, 1);
    expect_pkts(0, 0, 1);
    drive();
    tick();
    check("t5_c2_pop", 64'(pop_o), 64'(5'b00010));
    tick();
    check("t5_c3_pop", 64'(pop_o), 64'd0);
    check("t5_c3_gnt", 64'(gnt_o), 64'(5'b00010));
    tick();
    check("t5_c4_busy", 64'(busy_o), 64'd0);
    tick();
    check("t5_c5_gnt", 64'(gnt_o), 64'(5'b01000));
    drain(100, b);

    // Reset the cycle after a pop; second popped packet is lost
    do_reset();
    load(2, 5);
    expect_pkts(2, 0, 1);
    drive();
    tick();
    check("t6_c1_pop", 64'(pop_o), 64'(5'b00100));
    tick();
    check("t6_c2_push", 64'(push_o), 64'd1);
    reset = 1'b0;
    drive();
    tick();
    check("t6_rst_push", 64'(push_o), 64'd0);
    check("t6_rst_gnt",  64'(gnt_o),  64'd0);
    check("t6_rst_pop",  64'(pop_o),  64'd0);
    check("t6_rst_busy", 64'(busy_o), 64'd0);
    check("t6_rst_data", 64'(data_o), 64'd0);
    load(0, 1);
    expect_pkts(0, 0, 1);
    expect_pkts(2, 2, 3);
    drive();
    tick();
    reset = 1'b1;
    drive();
    tick();
    check("t6_gnt0", 64'(gnt_o), 64'(5'b00001));
    drain(100, b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
